// File: rtl/grant_bus_xfer.sv
// Grant-driven burst mover: forwards the granted agent's beats onto a shared
// valid/ready target bus, counting burst length and reporting done/abort.
module grant_bus_xfer #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic              gnt_2,
    input  logic              gnt_3,
    input  logic              agent_valid_0,
    input  logic              agent_valid_1,
    input  logic              agent_valid_2,
    input  logic              agent_valid_3,
    input  logic [DATA_W-1:0] agent_data_0,
    input  logic [DATA_W-1:0] agent_data_1,
    input  logic [DATA_W-1:0] agent_data_2,
    input  logic [DATA_W-1:0] agent_data_3,
    input  logic [LEN_W-1:0]  agent_len_0,
    input  logic [LEN_W-1:0]  agent_len_1,
    input  logic [LEN_W-1:0]  agent_len_2,
    input  logic [LEN_W-1:0]  agent_len_3,
    output logic              agent_ready_0,
    output logic              agent_ready_1,
    output logic              agent_ready_2,
    output logic              agent_ready_3,
    output logic              done_0,
    output logic              done_1,
    output logic              done_2,
    output logic              done_3,
    output logic              abort_0,
    output logic              abort_1,
    output logic              abort_2,
    output logic              abort_3,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic [1:0]        bus_src,
    output logic              bus_last,
    input  logic              bus_ready,
    output logic              busy,
    output logic              err_multi_gnt
);
    localparam int TMO_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, XFER, FIN, RELEASE} state_t;

    state_t             state, state_nx;
    logic [1:0]         src, src_nx;
    logic [LEN_W-1:0]   cnt, cnt_nx;
    logic [TMO_W-1:0]   tmo, tmo_nx;
    logic [3:0]         done_r, done_nx, abort_r, abort_nx;
    logic               err_r, err_nx;

    logic [3:0]         gnt_v, valid_v, ready_v;
    logic [DATA_W-1:0]  data_v [4];
    logic [LEN_W-1:0]   len_v [4];
    logic [2:0]         n_gnt;
    logic [1:0]         first_gnt;
    logic               in_xfer, beat;

    assign gnt_v   = {gnt_3, gnt_2, gnt_1, gnt_0};
    assign valid_v = {agent_valid_3, agent_valid_2, agent_valid_1, agent_valid_0};
    assign data_v[0] = agent_data_0;
    assign data_v[1] = agent_data_1;
    assign data_v[2] = agent_data_2;
    assign data_v[3] = agent_data_3;
    assign len_v[0]  = agent_len_0;
    assign len_v[1]  = agent_len_1;
    assign len_v[2]  = agent_len_2;
    assign len_v[3]  = agent_len_3;

    always_comb begin
        first_gnt = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (gnt_v[i]) first_gnt = 2'(i);
        end
        n_gnt = 3'(gnt_v[0]) + 3'(gnt_v[1]) + 3'(gnt_v[2]) + 3'(gnt_v[3]);
    end

    // Bus path is combinational and gated by state so reset silences it at once.
    assign in_xfer   = (state == XFER);
    assign bus_valid = in_xfer & valid_v[src];
    assign bus_data  = data_v[src];
    assign bus_src   = src;
    assign bus_last  = in_xfer & (cnt == '0);
    assign beat      = bus_valid & bus_ready;
    assign ready_v   = in_xfer ? ((4'b0001 << src) & {4{bus_ready}}) : 4'b0000;

    assign agent_ready_0 = ready_v[0];
    assign agent_ready_1 = ready_v[1];
    assign agent_ready_2 = ready_v[2];
    assign agent_ready_3 = ready_v[3];
    assign {done_3, done_2, done_1, done_0}     = done_r;
    assign {abort_3, abort_2, abort_1, abort_0} = abort_r;
    assign err_multi_gnt = err_r;
    assign busy          = (state != IDLE);

    always_comb begin
        state_nx = state;
        src_nx   = src;
        cnt_nx   = cnt;
        tmo_nx   = tmo;
        done_nx  = 4'b0000;
        abort_nx = 4'b0000;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (n_gnt == 3'd1) begin
                    src_nx   = first_gnt;
                    cnt_nx   = len_v[first_gnt];
                    tmo_nx   = '0;
                    state_nx = XFER;
                end else if (n_gnt > 3'd1) begin
                    err_nx = 1'b1;
                end
            end
            XFER: begin
                // Grant loss wins over a beat landing in the same cycle.
                if (!gnt_v[src]) begin
                    abort_nx[src] = 1'b1;
                    state_nx      = RELEASE;
                end else if (beat) begin
                    tmo_nx = '0;
                    if (cnt == '0) begin
                        done_nx[src] = 1'b1;
                        state_nx     = FIN;
                    end else begin
                        cnt_nx = cnt - LEN_W'(1);
                    end
                end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                    abort_nx[src] = 1'b1;
                    state_nx      = RELEASE;
                end else begin
                    tmo_nx = tmo + TMO_W'(1);
                end
            end
            FIN: state_nx = RELEASE;
            RELEASE: begin
                if (gnt_v == 4'b0000) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            src     <= 2'd0;
            cnt     <= '0;
            tmo     <= '0;
            done_r  <= 4'b0000;
            abort_r <= 4'b0000;
            err_r   <= 1'b0;
        end else begin
            state   <= state_nx;
            src     <= src_nx;
            cnt     <= cnt_nx;
            tmo     <= tmo_nx;
            done_r  <= done_nx;
            abort_r <= abort_nx;
            err_r   <= err_nx;
        end
    end
endmodule

// File: doc/grant_bus_xfer.md
Name: grant_bus_xfer

Overview:
- Downstream of the 4-agent request/grant FSM arbiter. Consumes its registered grants gnt_0..gnt_3.
- Multiplexes the granted agent's data beats onto one shared target bus using a valid/ready handshake. Counts a per-grant burst length.
- Pulses done to the owning agent so that agent can drop its request.
- Enforces grant release before the next transfer, aborts on grant loss or target stall timeout, and flags illegal multi-grant.

Parameters:
DATA_W, 32, width of agent and bus data
LEN_W, 4, burst length field width; len encodes beats-1 (0 = 1 beat, 15 = 16 beats)
TIMEOUT, 64, cycles with no completed beat in XFER before abort (must be >= 2)

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
gnt_0..gnt_3  input  1 each  grants from arbiter
agent_valid_0..agent_valid_3  input  1 each  agent beat valid
agent_data_0..agent_data_3  input  DATA_W each  agent beat data
agent_len_0..agent_len_3  input  LEN_W each  burst length-1, sampled at grant accept
agent_ready_0..agent_ready_3  output  1 each  beat accepted from agent
done_0..done_3  output  1 each  one-cycle pulse, burst completed
abort_0..abort_3  output  1 each  one-cycle pulse, burst aborted
bus_valid  output  1  beat valid to target
bus_data  output  DATA_W  beat data
bus_src  output  2  index of owning agent
bus_last  output  1  final beat of burst
bus_ready  input  1  target accepts beat
busy  output  1  state != IDLE
err_multi_gnt  output  1  one-cycle pulse, >1 grant seen in IDLE

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; src=0; beat counter=0; timeout counter=0.
  - All done/abort/err pulses are 0.
  - bus_valid=0 and all agent_ready=0, because both are gated by state.
- State machine: IDLE, XFER, FIN, RELEASE. Transitions occur on the clock edge.
- IDLE:
  - Exactly one gnt_i high: src<=i, cnt<=agent_len_i, tmo<=0, go to XFER.
  - More than one gnt high: err_multi_gnt pulses next cycle. Stay IDLE.
  - No gnt high: stay IDLE.
- XFER data path (combinational):
  - bus_valid = agent_valid_src.
  - bus_data = agent_data_src.
  - bus_src = src.
  - bus_last = (cnt==0).
  - agent_ready_src = bus_ready. All other agent_ready are 0.
  - A beat completes when bus_valid && bus_ready.
- XFER transitions:
  - gnt_src low: abort_src pulses next cycle, go to RELEASE. This check has priority over a beat completing in the same cycle; that beat is still consumed by the target.
  - Beat completes with cnt==0: go to FIN.
  - Beat completes with cnt!=0: cnt<=cnt-1, tmo<=0.
  - No beat: tmo<=tmo+1. When tmo reaches TIMEOUT-1 with no beat, abort_src pulses and go to RELEASE.
  - Grants to agents other than src are ignored during XFER.
- FIN: done_src is high for exactly this one cycle. Go to RELEASE.
- RELEASE:
  - bus_valid=0.
  - Wait until all gnt are low, then go to IDLE.
  - This absorbs the arbiter's registered-grant lag, so a stale grant is never re-accepted as a new burst.
- Outputs other than the bus path are registered. done/abort/err never assert for more than one cycle per event.
- Reset asserted mid-burst: bus_valid drops immediately. No done or abort is issued.

Test Plan:
- Single-beat burst:
  - Stimulus: gnt_1=1, agent_len_1=0, agent_valid_1=1, bus_ready=1.
  - Required: bus_valid=1 with bus_src=1 and bus_last=1 for one cycle; done_1 pulses; busy stays high until gnt_1 drops, then IDLE.
- 4-beat burst with backpressure:
  - Stimulus: gnt_2, agent_len_2=3, data 0xA0..0xA3; bus_ready toggles 1,0,1,0.
  - Required: exactly four accepted beats in order; bus_last only on 0xA3; agent_ready_2 mirrors bus_ready; done_2 once.
- Grant loss:
  - Stimulus: gnt_0 burst with len=7; gnt_0 drops after beat 3.
  - Required: abort_0 pulse; no done_0; no further bus_valid; return to IDLE.
- Timeout:
  - Stimulus: TIMEOUT=8; gnt_3 held; agent_valid_3=1; bus_ready=0 held.
  - Required: abort_3 after 8 XFER cycles; state goes to RELEASE.
- Multi-grant:
  - Stimulus: gnt_0 and gnt_2 high together in IDLE.
  - Required: err_multi_gnt pulses every such cycle; busy=0; no bus_valid.
- Async reset mid-burst:
  - Stimulus: reset_n pulled low between clock edges during XFER.
  - Required: bus_valid, busy and all pulses are 0 immediately; IDLE after release.
